// File: rtl/bit_stuff_stream.sv
// Serial bit stuffer: inserts a 0 after MAX_ONES consecutive 1s, leaving the packet sync field
// unstuffed. Define BIT_STUFF_NRZI_EN to NRZI-encode out_bit.
module bit_stuff_stream #(
  parameter int unsigned MAX_ONES  = 6,
  parameter int unsigned SKIP_BITS = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             start,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             pause,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SKIP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  localparam logic [3:0] ONES_MAX = 4'(MAX_ONES);
  localparam logic [4:0] SKIP_MAX = 5'(SKIP_BITS);

`ifdef BIT_STUFF_NRZI_EN
  localparam logic BIT_RST = 1'b1;
`else
  localparam logic BIT_RST = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [3:0]       ones_q, ones_d;
  logic [4:0]       skip_q, skip_d;
  logic [CNT_W-1:0] stuff_q, stuff_d, stuff_inc;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_bit_q, out_bit_d;
  logic             raw_d;
  logic             accept;

  // Decoded from registered state only, so upstream sees no combinational loop.
  assign pause  = (state_q == RUN && ones_q == ONES_MAX) || (state_q == TAIL);
  assign accept = in_valid & ~pause;
  assign stuff_inc = (stuff_q == '1) ? stuff_q : stuff_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    skip_d      = skip_q;
    stuff_d     = stuff_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    raw_d       = 1'b0;

    if (state_q == TAIL) begin
      out_valid_d = 1'b1;
      out_last_d  = 1'b1;
      stuff_d     = stuff_inc;
      ones_d      = 4'd0;
      state_d     = IDLE;
    end else if (pause) begin
      // Stuffed 0; the held input bit is consumed on a later cycle.
      out_valid_d = 1'b1;
      ones_d      = 4'd0;
      stuff_d     = stuff_inc;
    end else if (accept && start) begin
      out_valid_d = 1'b1;
      raw_d       = in_bit;
      stuff_d     = '0;
      ones_d      = 4'd0;
      skip_d      = 5'd1;
      if (in_last) begin
        out_last_d = 1'b1;
        state_d    = IDLE;
      end else begin
        state_d = (SKIP_BITS == 1) ? RUN : SKIP;
      end
    end else if (accept) begin
      case (state_q)
        SKIP: begin
          out_valid_d = 1'b1;
          raw_d       = in_bit;
          skip_d      = skip_q + 5'd1;
          if (skip_q + 5'd1 == SKIP_MAX) state_d = RUN;
          if (in_last) begin
            out_last_d = 1'b1;
            state_d    = IDLE;
          end
        end
        RUN: begin
          out_valid_d = 1'b1;
          raw_d       = in_bit;
          ones_d      = in_bit ? ones_q + 4'd1 : 4'd0;
          if (in_last) begin
            if (in_bit && ones_q + 4'd1 == ONES_MAX) begin
              state_d = TAIL;
            end else begin
              out_last_d = 1'b1;
              ones_d     = 4'd0;
              state_d    = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIT_STUFF_NRZI_EN
  logic level_base;
  // Level restarts at 1 in the cycle after a packet's final bit.
  assign level_base = out_last_q ? 1'b1 : out_bit_q;
  assign out_bit_d  = out_valid_d ? (raw_d ? level_base : ~level_base) : level_base;
`else
  assign out_bit_d  = raw_d;
`endif

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      ones_q      <= 4'd0;
      skip_q      <= 5'd0;
      stuff_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bit_q   <= BIT_RST;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      skip_q      <= skip_d;
      stuff_q     <= stuff_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign stuff_cnt = stuff_q;

endmodule

// File: tb/tb_bit_stuff_stream.sv
// Directed table-driven bench for bit_stuff_stream (default parameters).
module tb_bit_stuff_stream;

  logic       clk = 1'b0;
  logic       rst_L;
  logic       start, in_bit, in_valid, in_last;
  logic       pause, out_bit, out_valid, out_last;
  logic [7:0] stuff_cnt;

  bit_stuff_stream dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .start    (start),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_last  (in_last),
    .pause    (pause),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_last (out_last),
    .stuff_cnt(stuff_cnt)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs, expected pause in that cycle, expected outputs after its edge.
  typedef struct {
    logic s, b, v, l;
    logic p, ov, ob, ol;
    int   sc;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_level;
  logic m_last;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic vec(input logic s, b, v, l, p, ov, ob, ol, input int sc);
    vec_t e;
    e.s = s; e.b = b; e.v = v; e.l = l;
    e.p = p; e.ov = ov; e.ob = ob; e.ol = ol; e.sc = sc;
    vq.push_back(e);
  endtask

  task automatic ones(input int n, input int sc);
    for (int i = 0; i < n; i++) vec(0, 1, 1, 0, 0, 1, 1, 0, sc);
  endtask

  task automatic idle(input int sc);
    vec(0, 0, 0, 0, 0, 0, 0, 0, sc);
  endtask

  function automatic logic exp_bit(input logic ov, input logic ob, input logic ol);
    logic base;
`ifdef BIT_STUFF_NRZI_EN
    base    = m_last ? 1'b1 : m_level;
    m_level = ov ? (ob ? base : ~base) : base;
    m_last  = ol;
    return m_level;
`else
    base = ov & ob;
    m_last = ol;
    return base;
`endif
  endfunction

  task automatic run_table();
    logic eb;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].s; in_bit = vq[i].b; in_valid = vq[i].v; in_last = vq[i].l;
      #1;
      check("pause", i, int'(pause), int'(vq[i].p));
      @(posedge clk);
      #1;
      eb = exp_bit(vq[i].ov, vq[i].ob, vq[i].ol);
      check("out_valid", i, int'(out_valid), int'(vq[i].ov));
      check("out_bit", i, int'(out_bit), int'(eb));
      check("out_last", i, int'(out_last), int'(vq[i].ol));
      check("stuff_cnt", i, int'(stuff_cnt), vq[i].sc);
    end
    vq.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pause"}, -1, int'(pause), 0);
    check({tag, "_out_valid"}, -1, int'(out_valid), 0);
    check({tag, "_out_last"}, -1, int'(out_last), 0);
    check({tag, "_stuff_cnt"}, -1, int'(stuff_cnt), 0);
`ifdef BIT_STUFF_NRZI_EN
    check({tag, "_out_bit"}, -1, int'(out_bit), 1);
`else
    check({tag, "_out_bit"}, -1, int'(out_bit), 0);
`endif
    m_level = 1'b1;
    m_last  = 1'b0;
  endtask

  initial begin
    start = 0; in_bit = 0; in_valid = 0; in_last = 0;
    rst_L = 0;
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_L = 1;

    // Packet into RUN with one stuff, then asynchronous reset mid-packet.
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(6, 0);
    vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
    ones(2, 1);
    run_table();
    rst_L = 0;
    #1;
    reset_checks("midrst");
    @(negedge clk);
    start = 0; in_bit = 0; in_valid = 0; in_last = 0;
    rst_L = 1;

    // Skip 8 ones, then 7 ones with last: 6x1, stuffed 0, 1 (last).
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(6, 0);
    vec(0, 1, 1, 1, 1, 1, 0, 0, 1);
    vec(0, 1, 1, 1, 0, 1, 1, 1, 1);
    idle(1);

    // Last on the 6th run one: out_last withheld, tail stuff carries it.
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(5, 0);
    vec(0, 1, 1, 1, 0, 1, 1, 0, 0);
    vec(0, 0, 0, 0, 1, 1, 0, 1, 1);
    idle(1);

    // Bit without start is dropped; count holds. Then gap mid-run and stuff during a gap.
    vec(0, 1, 1, 0, 0, 0, 0, 0, 1);
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(3, 0);
    idle(0); idle(0); idle(0);
    ones(3, 0);
    vec(0, 0, 0, 0, 1, 1, 0, 0, 1);
    vec(0, 0, 1, 1, 0, 1, 0, 1, 1);
    idle(1);

    // Restart at bit 20: count cleared, no out_last, skip field not stuffed.
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(6, 0);
    vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
    ones(2, 1);
    vec(0, 0, 1, 0, 0, 1, 0, 0, 1);
    ones(2, 1);
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    vec(0, 1, 1, 1, 0, 1, 1, 1, 0);
    idle(0);

    // Twelve run ones: 111111 0 111111 0, then a 0 with last.
    vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    ones(7, 0);
    ones(6, 0);
    vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
    ones(6, 1);
    vec(0, 0, 1, 1, 1, 1, 0, 0, 2);
    vec(0, 0, 1, 1, 0, 1, 0, 1, 2);
    idle(2);

    // NRZI-visible pattern: raw 0,1,1,0 within the skip field.
    vec(1, 0, 1, 0, 0, 1, 0, 0, 0);
    vec(0, 1, 1, 0, 0, 1, 1, 0, 0);
    vec(0, 1, 1, 0, 0, 1, 1, 0, 0);
    vec(0, 0, 1, 1, 0, 1, 0, 1, 0);
    idle(0);
    idle(0);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
